k005297_rotation_sequencer: RTL and testbench

- Downstream consumer of the supervisor's 2 MHz subclock enable, 20-phase rotator and system-run flag.
- Turns each full 20-phase rotator revolution into one bubble field-rotation period.
- Tracks the absolute bit position of the minor loops and emits per-rotation detect/replicate strobes at fixed rotator phases.
- Feeds the bubble read/write datapath, which samples on the strobes and uses the bit position for page alignment.

---
 rtl/k005297_rotation_sequencer_if.sv | 27 ++
 rtl/k005297_rotation_sequencer.sv | 114 +++++++++++
 tb/tb_k005297_rotation_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/k005297_rotation_sequencer_if.sv
// Bundles the sequencer's subclock/rotator inputs and its position/strobe outputs.
// The supervisor side drives the inputs as master; the sequencer is the slave.
interface k005297_rotation_sequencer_if #(
  parameter int POS_W = 10
);
  logic             i_CLK2M_PCEN_n;
  logic [19:0]      i_ROT20_n;
  logic             i_SYS_RUN_FLAG;
  logic             i_START;
  logic             i_STOP;
  logic [POS_W-1:0] o_BITPOS;
  logic             o_PAGE_SYNC;
  logic             o_DETECT_STB;
  logic             o_REPL_STB;
  logic             o_BUSY;
  logic             o_ROT20_ERR;

  modport master (
    output i_CLK2M_PCEN_n, i_ROT20_n, i_SYS_RUN_FLAG, i_START, i_STOP,
    input  o_BITPOS, o_PAGE_SYNC, o_DETECT_STB, o_REPL_STB, o_BUSY, o_ROT20_ERR
  );

  modport slave (
    input  i_CLK2M_PCEN_n, i_ROT20_n, i_SYS_RUN_FLAG, i_START, i_STOP,
    output o_BITPOS, o_PAGE_SYNC, o_DETECT_STB, o_REPL_STB, o_BUSY, o_ROT20_ERR
  );
endinterface

// File: rtl/k005297_rotation_sequencer.sv
// Converts 20-phase rotator revolutions into bubble field rotations and tracks
// the minor-loop bit position, emitting detect/replicate strobes at fixed phases.
module k005297_rotation_sequencer #(
  parameter int LOOP_LEN     = 641,
  parameter int POS_W        = 10,
  parameter int DETECT_PHASE = 11,
  parameter int REPL_PHASE   = 4
) (
  input  logic i_MCLK,
  input  logic i_MRST,
  k005297_rotation_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, STOPPING} state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] bitpos_q, bitpos_d;
  logic             page_q, page_d;
  logic             det_q, det_d;
  logic             repl_q, repl_d;
  logic             err_q, err_d;

  logic [19:0] rot;
  logic        legal;
  logic [4:0]  phase;
  logic        en;
  logic        ph19;

  assign rot   = ~bus.i_ROT20_n;
  assign legal = (rot != 20'd0) && ((rot & (rot - 20'd1)) == 20'd0);
  assign en    = ~bus.i_CLK2M_PCEN_n;
  assign ph19  = legal && (phase == 5'd19);

  always_comb begin
    phase = 5'd0;
    for (int k = 0; k < 20; k++)
      if (rot[k]) phase = 5'(k);
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    bitpos_d = bitpos_q;
    page_d   = page_q;
    det_d    = det_q;
    repl_d   = repl_q;
    err_d    = err_q;

    if (!bus.i_SYS_RUN_FLAG) begin
      // Run-flag loss acts on any master clock edge, not just enabled ones.
      state_d = IDLE;
      page_d  = 1'b0;
      det_d   = 1'b0;
      repl_d  = 1'b0;
    end else if (en) begin
      page_d = 1'b0;
      det_d  = 1'b0;
      repl_d = 1'b0;
      if (state_q != IDLE && !legal) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        if (state_q == RUN || state_q == STOPPING) begin
          det_d  = (phase == 5'(DETECT_PHASE));
          repl_d = (phase == 5'(REPL_PHASE));
          if (ph19) begin
            if (bitpos_q == POS_W'(LOOP_LEN - 1)) begin
              bitpos_d = '0;
              page_d   = 1'b1;
            end else begin
              bitpos_d = bitpos_q + 1'b1;
            end
          end
        end
        unique case (state_q)
          IDLE:     if (bus.i_START && !bus.i_STOP) state_d = ARMED;
          ARMED:    if (bus.i_STOP) state_d = IDLE;
                    else if (ph19) state_d = RUN;
          RUN:      if (bus.i_STOP) state_d = ph19 ? IDLE : STOPPING;
          STOPPING: if (ph19) state_d = IDLE;
          default:  state_d = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers.
  always_ff @(posedge i_MCLK or posedge i_MRST) begin
    if (i_MRST) begin
      state_q  <= IDLE;
      bitpos_q <= '0;
      page_q   <= 1'b0;
      det_q    <= 1'b0;
      repl_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitpos_q <= bitpos_d;
      page_q   <= page_d;
      det_q    <= det_d;
      repl_q   <= repl_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_BITPOS     = bitpos_q;
  assign bus.o_PAGE_SYNC  = page_q;
  assign bus.o_DETECT_STB = det_q;
  assign bus.o_REPL_STB   = repl_q;
  assign bus.o_BUSY       = (state_q != IDLE);
  assign bus.o_ROT20_ERR  = err_q;

endmodule

// File: tb/tb_k005297_rotation_sequencer.sv
// Directed bench for the rotation sequencer: start/strobe timing, wrap, stop,
// run-flag override, illegal rotator and asynchronous reset.
module tb_k005297_rotation_sequencer;
  logic i_MCLK = 1'b0;
  logic i_MRST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  k005297_rotation_sequencer_if #(.POS_W(10)) bus ();

  k005297_rotation_sequencer #(
    .LOOP_LEN(641), .POS_W(10), .DETECT_PHASE(11), .REPL_PHASE(4)
  ) dut (
    .i_MCLK (i_MCLK),
    .i_MRST (i_MRST),
    .bus    (bus.slave)
  );

  always #5 i_MCLK = ~i_MCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One enabled edge at the given rotator pattern; returns at the following negedge.
  task automatic step_raw(input logic [19:0] pat);
    @(negedge i_MCLK);
    bus.i_ROT20_n      = pat;
    bus.i_CLK2M_PCEN_n = 1'b0;
    @(negedge i_MCLK);
    bus.i_CLK2M_PCEN_n = 1'b1;
  endtask

  task automatic step(input int ph);
    logic [19:0] pat;
    pat = ~(20'd1 << ph);
    step_raw(pat);
  endtask

  task automatic steps(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) step(p);
  endtask

  task automatic rotate(input int n);
    for (int r = 0; r < n; r++) steps(0, 19);
  endtask

  initial begin
    bus.i_CLK2M_PCEN_n = 1'b1;
    bus.i_ROT20_n      = 20'hFFFFE;
    bus.i_SYS_RUN_FLAG = 1'b0;
    bus.i_START        = 1'b0;
    bus.i_STOP         = 1'b0;
    #2;
    check("rst_bitpos", 32'(bus.o_BITPOS), 0);
    check("rst_busy", 32'(bus.o_BUSY), 0);
    check("rst_err", 32'(bus.o_ROT20_ERR), 0);
    check("rst_strobes", {29'd0, bus.o_PAGE_SYNC, bus.o_DETECT_STB, bus.o_REPL_STB}, 0);
    @(negedge i_MCLK);
    i_MRST = 1'b0;
    bus.i_SYS_RUN_FLAG = 1'b1;

    // Start at phase 7, arm, enter RUN at phase 19.
    steps(0, 6);
    check("idle_busy", 32'(bus.o_BUSY), 0);
    bus.i_START = 1'b1;
    step(7);
    bus.i_START = 1'b0;
    check("armed_busy", 32'(bus.o_BUSY), 1);
    steps(8, 19);
    check("armed_bitpos", 32'(bus.o_BITPOS), 0);
    steps(0, 3);
    check("repl_before", 32'(bus.o_REPL_STB), 0);
    step(4);
    check("repl_fire", 32'(bus.o_REPL_STB), 1);
    step(5);
    check("repl_clear", 32'(bus.o_REPL_STB), 0);
    steps(6, 11);
    check("det_fire", 32'(bus.o_DETECT_STB), 1);
    step(12);
    check("det_clear", 32'(bus.o_DETECT_STB), 0);
    steps(13, 18);
    check("bitpos_pre19", 32'(bus.o_BITPOS), 0);
    step(19);
    check("bitpos_first", 32'(bus.o_BITPOS), 1);

    // Wrap 640 -> 0 with a single-period page sync.
    rotate(639);
    check("bitpos_640", 32'(bus.o_BITPOS), 640);
    check("page_before", 32'(bus.o_PAGE_SYNC), 0);
    rotate(1);
    check("wrap_bitpos", 32'(bus.o_BITPOS), 0);
    check("page_fire", 32'(bus.o_PAGE_SYNC), 1);
    step(0);
    check("page_clear", 32'(bus.o_PAGE_SYNC), 0);

    // Mid-rotation stop at phase 5: rotation completes.
    steps(1, 4);
    bus.i_STOP = 1'b1;
    step(5);
    bus.i_STOP = 1'b0;
    check("stopping_busy", 32'(bus.o_BUSY), 1);
    steps(6, 11);
    check("stopping_det", 32'(bus.o_DETECT_STB), 1);
    steps(12, 19);
    check("stop_bitpos", 32'(bus.o_BITPOS), 1);
    check("stop_idle", 32'(bus.o_BUSY), 0);
    rotate(1);
    check("idle_hold", 32'(bus.o_BITPOS), 1);

    // Restart resumes counting.
    bus.i_START = 1'b1;
    step(3);
    bus.i_START = 1'b0;
    steps(4, 19);
    rotate(1);
    check("restart_bitpos", 32'(bus.o_BITPOS), 2);

    // Run-flag drop between enabled edges.
    steps(0, 8);
    check("run_busy", 32'(bus.o_BUSY), 1);
    @(negedge i_MCLK);
    bus.i_SYS_RUN_FLAG = 1'b0;
    @(posedge i_MCLK);
    #1;
    check("runflag_busy", 32'(bus.o_BUSY), 0);
    check("runflag_bitpos", 32'(bus.o_BITPOS), 2);
    bus.i_SYS_RUN_FLAG = 1'b1;

    // Simultaneous start and stop in IDLE: stop wins.
    bus.i_START = 1'b1;
    bus.i_STOP  = 1'b1;
    step(0);
    bus.i_STOP  = 1'b0;
    check("startstop_busy", 32'(bus.o_BUSY), 0);

    // Illegal rotator while running.
    step(1);
    bus.i_START = 1'b0;
    steps(2, 19);
    steps(0, 2);
    step_raw(20'hFFFFF);
    check("illegal_err", 32'(bus.o_ROT20_ERR), 1);
    check("illegal_busy", 32'(bus.o_BUSY), 0);
    check("illegal_bitpos", 32'(bus.o_BITPOS), 2);
    step(3);
    check("err_sticky", 32'(bus.o_ROT20_ERR), 1);

    @(negedge i_MCLK);
    i_MRST = 1'b1;
    #1;
    check("rst2_err", 32'(bus.o_ROT20_ERR), 0);
    check("rst2_bitpos", 32'(bus.o_BITPOS), 0);
    @(negedge i_MCLK);
    i_MRST = 1'b0;
    step_raw(20'hFFFFF);
    check("idle_illegal_err", 32'(bus.o_ROT20_ERR), 0);
    step_raw(20'hFFFFC);
    check("idle_twocold_err", 32'(bus.o_ROT20_ERR), 0);

    // Async reset mid-RUN at bit position 300.
    bus.i_START = 1'b1;
    step(0);
    bus.i_START = 1'b0;
    steps(1, 19);
    rotate(300);
    check("bitpos_300", 32'(bus.o_BITPOS), 300);
    steps(0, 4);
    check("pre_rst_repl", 32'(bus.o_REPL_STB), 1);
    @(negedge i_MCLK);
    i_MRST = 1'b1;
    #1;
    check("async_bitpos", 32'(bus.o_BITPOS), 0);
    check("async_busy", 32'(bus.o_BUSY), 0);
    check("async_strobes", {29'd0, bus.o_PAGE_SYNC, bus.o_DETECT_STB, bus.o_REPL_STB}, 0);
    check("async_err", 32'(bus.o_ROT20_ERR), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
